fft_frame_buffer: RTL

FFT_FRAME_BUFFER -- requirements
Module: fft_frame_buffer

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_frame_buffer_if.sv | 32 +++
 rtl/fft_frame_bank.sv | 28 ++
 rtl/fft_frame_buffer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, read-side state encoding and address helper for the FFT
// frame buffer slice.
package fft_pkg;

    localparam int WIDTH_DEF = 36;
    localparam int NPTS      = 16;
    localparam int PTR_W     = 4;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_LAUNCH = 2'd1,
        RD_WAIT   = 2'd2
    } rd_state_t;

    // Reverse the 4 address bits so a DIT core sees its inputs in bit-reversed order.
    function automatic logic [PTR_W-1:0] bitrev4(input logic [PTR_W-1:0] a);
        return {a[0], a[1], a[2], a[3]};
    endfunction

endpackage

// File: rtl/fft_frame_buffer_if.sv
// Streaming-sample input and parallel-frame output bundle of fft_frame_buffer.
interface fft_frame_buffer_if #(
    parameter int WIDTH = fft_pkg::WIDTH_DEF,
    parameter int NPTS  = fft_pkg::NPTS
);
    import fft_pkg::*;

    // Handshake: a sample transfers on a rising edge where sample_valid and
    // sample_ready are both high; the producer holds sample_in steady while
    // sample_valid is high and sample_ready is low. The frame side has no
    // backpressure: start is a single-cycle pulse, fft_done a single-cycle strobe.
    logic signed [WIDTH-1:0] sample_in;
    logic                    sample_valid;
    logic                    sample_ready;
    logic signed [WIDTH-1:0] f [0:NPTS-1];
    logic                    start;
    logic                    fft_done;
    logic [CNT_W-1:0]        frame_count;
    rd_state_t               rd_state;
    logic [1:0]              full_dbg;

    modport master (
        output sample_in, sample_valid, fft_done,
        input  sample_ready, f, start, frame_count, rd_state, full_dbg
    );

    modport slave (
        input  sample_in, sample_valid, fft_done,
        output sample_ready, f, start, frame_count, rd_state, full_dbg
    );

endinterface

// File: rtl/fft_frame_bank.sv
// One 16-entry sample bank: single write port, every entry readable in parallel.
// Contents are deliberately not reset.
module fft_frame_bank #(
    parameter int WIDTH = fft_pkg::WIDTH_DEF,
    parameter int NPTS  = fft_pkg::NPTS
) (
    input  logic                    clock,
    input  logic                    we,
    input  logic [3:0]              waddr,
    input  logic signed [WIDTH-1:0] wdata,
    output logic signed [WIDTH-1:0] rdata [0:NPTS-1]
);

    logic signed [WIDTH-1:0] mem [0:NPTS-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < NPTS; i++) begin
            rdata[i] = mem[i];
        end
    end

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer feeding a 16-point FFT: streams samples into two banks
// and presents each full bank in parallel. Build option: FFT_BITREV_IN_EN.
module fft_frame_buffer #(
    parameter int WIDTH = fft_pkg::WIDTH_DEF,
    parameter int NPTS  = fft_pkg::NPTS
) (
    input  logic              clock,
    input  logic              reset,
    fft_frame_buffer_if.slave bus
);
    import fft_pkg::*;

    logic [PTR_W-1:0]        wr_ptr;
    logic                    wr_bank;
    logic                    rd_bank;
    logic [1:0]              full;
    logic [CNT_W-1:0]        frame_count_q;
    rd_state_t               state;
    rd_state_t               state_nxt;

    logic                    accept;
    logic                    frame_fill;
    logic                    frame_release;
    logic [1:0]              full_set;
    logic [1:0]              full_clr;
    logic [1:0]              bank_we;
    logic [PTR_W-1:0]        waddr;
    logic signed [WIDTH-1:0] bank0_q [0:NPTS-1];
    logic signed [WIDTH-1:0] bank1_q [0:NPTS-1];

    // ---------------- write side ----------------
    assign accept        = bus.sample_valid && !full[wr_bank];
    assign frame_fill    = accept && (wr_ptr == 4'd15);
    assign frame_release = (state == RD_WAIT) && bus.fft_done;
    assign bank_we       = {accept && wr_bank, accept && !wr_bank};

`ifdef FFT_BITREV_IN_EN
    assign waddr = bitrev4(wr_ptr);
`else
    assign waddr = wr_ptr;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
        end else if (accept) begin
            wr_ptr <= wr_ptr + 4'd1;
            if (frame_fill) begin
                wr_bank <= !wr_bank;
            end
        end
    end

    fft_frame_bank #(.WIDTH(WIDTH), .NPTS(NPTS)) u_bank0 (
        .clock (clock),
        .we    (bank_we[0]),
        .waddr (waddr),
        .wdata (bus.sample_in),
        .rdata (bank0_q)
    );

    fft_frame_bank #(.WIDTH(WIDTH), .NPTS(NPTS)) u_bank1 (
        .clock (clock),
        .we    (bank_we[1]),
        .waddr (waddr),
        .wdata (bus.sample_in),
        .rdata (bank1_q)
    );

    // ---------------- full flags ----------------
    // A fill and a release may land on the same edge; each touches only its own bank.
    always_comb begin
        full_set = '0;
        full_clr = '0;
        if (frame_fill) begin
            full_set[wr_bank] = 1'b1;
        end
        if (frame_release) begin
            full_clr[rd_bank] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full <= '0;
        end else begin
            full <= (full & ~full_clr) | full_set;
        end
    end

    // ---------------- read side ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_bank       <= 1'b0;
            frame_count_q <= '0;
        end else if (frame_release) begin
            rd_bank       <= !rd_bank;
            frame_count_q <= frame_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Looking at the pending fill lets start follow the 16th write by one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE: begin
                if (full[rd_bank] || full_set[rd_bank]) begin
                    state_nxt = RD_LAUNCH;
                end
            end
            RD_LAUNCH: begin
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.fft_done) begin
                    state_nxt = RD_IDLE;
                end
            end
            default: begin
                state_nxt = RD_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.start = (state == RD_LAUNCH);
    end

    always_comb begin
        for (int i = 0; i < NPTS; i++) begin
            bus.f[i] = rd_bank ? bank1_q[i] : bank0_q[i];
        end
    end

    assign bus.sample_ready = !full[wr_bank];
    assign bus.frame_count  = frame_count_q;
    assign bus.rd_state     = state;
    assign bus.full_dbg     = full;

endmodule
